conv_window_fetch: RTL and testbench
====================================

Name: conv_window_fetch

Overview:
- Downstream consumer of the 28x28 image memory (784 x 8-bit, two read ports, 1-cycle registered read latency, read enable).
- Scans every valid 3x3 convolution position (26x26 = 676 windows, row-major), drives both memory read ports, and assembles each window's 9 pixels.
- Hands each assembled window to the conv datapath over a valid/ready handshake.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- DATA_W, 8, pixel width (signed)
- ADDR_W, 10, memory address width

Ports:
- clk  in  1  clock; everything on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  1-cycle pulse; begins a full image scan when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  1-cycle pulse after the last window handshakes
- mem_en  out  1  read enable to image memory (its load input)
- mem_addr1  out  ADDR_W  port-1 read address
- mem_addr2  out  ADDR_W  port-2 read address
- mem_data1  in  DATA_W  port-1 read data, valid 1 cycle after the address
- mem_data2  in  DATA_W  port-2 read data, valid 1 cycle after the address
- win_valid  out  1  window available
- win_ready  in  1  consumer accepts the window
- win_data  out  9*DATA_W  taps; tap t occupies bits [8t+7:8t]; t = 3*dr + dc; tap0 = top-left
- win_row  out  5  output row of the current window (0..IMG_H-3)
- win_col  out  5  output column of the current window (0..IMG_W-3)

Behaviour:
- Reset values: all outputs 0; state IDLE; row/col counters 0. Reset at any point, including mid-scan or while win_valid is high, aborts the scan and returns to IDLE the next cycle with no done pulse.
- States: IDLE, FETCH, DRAIN, OUT, DONE.
- IDLE: start=1 -> FETCH with row=col=0 and pair index k=0. Start is ignored in every other state.
- Base address: base = row*IMG_W + col. Tap t address = base + (t/3)*IMG_W + (t%3), computed at ADDR_W bits with no overflow (max 783).
- FETCH lasts 5 cycles, k = 0..4, with mem_en=1.
  - For k<4: mem_addr1 = tap 2k, mem_addr2 = tap 2k+1.
  - For k=4: both addresses = tap 8.
  - In cycle k (k>=1), capture mem_data1/mem_data2 into taps 2(k-1) and 2(k-1)+1.
  - After k=4 -> DRAIN.
- DRAIN: 1 cycle, mem_en=0. Capture mem_data1 into tap 8; mem_data2 is ignored. -> OUT.
- OUT:
  - win_valid=1.
  - win_data, win_row and win_col are held stable until the handshake.
  - mem_en=0; no addresses are issued while stalled.
- Handshake: valid & ready at a clock edge = transfer.
  - If this is the last window (row=IMG_H-3, col=IMG_W-3) -> DONE.
  - Otherwise col increments; on col=IMG_W-3 it wraps to 0 and row increments. Next state is FETCH with k=0.
  - win_valid drops in the cycle after the transfer.
- DONE: done=1 for exactly 1 cycle, busy=0 -> IDLE.
- busy is high in FETCH, DRAIN and OUT.
- Throughput: 7 cycles per window with win_ready held high. A full scan takes 676*7 cycles plus the DONE cycle.
- mem_addr1/mem_addr2 hold their last value when mem_en=0. They return to 0 only on reset.

Test Plan:
- Image memory preloaded with mem[i] = i mod 256, win_ready=1, start pulse -> first FETCH issues address pairs (0,1), (2,28), (29,30), (56,57), (58,58). First window = taps 0,1,2,28,29,30,56,57,58 with win_row=0, win_col=0.
- Same run to completion -> exactly 676 win_valid/win_ready transfers. The last window (row 25, col 25) has taps 213,214,215,241,242,243,13,14,15. Then one done pulse, and busy falls.
- win_ready held low for 10 cycles on window (0,1) -> win_valid stays 1, win_data/win_row/win_col stay constant, and mem_en=0 throughout. On the ready edge, window (0,2) is fetched next.
- Column wrap: after window (0,25), the next window is (1,0) with base 28 and taps 28,29,30,56,57,58,84,85,86.
- rst asserted during window (3,7) FETCH -> next cycle all outputs are 0 and the state is IDLE. A new start restarts at (0,0) with correct data.
- start pulsed while busy -> ignored: the window sequence and total count are unchanged, and there is no extra done pulse.

Source files
------------

// File: rtl/conv_window_fetch.sv
`timescale 1ns/1ps
// Scans every valid 3x3 window of an IMG_W x IMG_H image held in a dual-port memory
// and hands each assembled window to the conv datapath over a valid/ready handshake.
module conv_window_fetch #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     mem_addr1,
  output logic [ADDR_W-1:0]     mem_addr2,
  input  logic [DATA_W-1:0]     mem_data1,
  input  logic [DATA_W-1:0]     mem_data2,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [9*DATA_W-1:0]   win_data,
  output logic [4:0]            win_row,
  output logic [4:0]            win_col
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST_ROW = 5'(IMG_H - 3);
  localparam logic [4:0] LAST_COL = 5'(IMG_W - 3);

  state_t              state, state_nxt;
  logic [4:0]          row, col;
  logic [2:0]          k;
  logic [DATA_W-1:0]   taps [9];
  logic [ADDR_W-1:0]   addr1_q, addr2_q;
  logic [ADDR_W-1:0]   base, fetch_a1, fetch_a2;
  logic [3:0]          t1, t2, cap_idx;
  logic                last_win;

  function automatic logic [ADDR_W-1:0] tap_off(input int unsigned t);
    return ADDR_W'((t / 3) * IMG_W + (t % 3));
  endfunction

  assign base     = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
  // Pair k covers taps 2k and 2k+1; the ninth tap is issued alone on both ports.
  assign t1       = (k == 3'd4) ? 4'd8 : {k, 1'b0};
  assign t2       = (k == 3'd4) ? 4'd8 : {k, 1'b1};
  assign fetch_a1 = base + tap_off({28'b0, t1});
  assign fetch_a2 = base + tap_off({28'b0, t2});
  assign cap_idx  = {k - 3'd1, 1'b0};
  assign last_win = (row == LAST_ROW) && (col == LAST_COL);

  // Addresses are live during FETCH and otherwise hold the last issued pair.
  assign mem_addr1 = (state == S_FETCH) ? fetch_a1 : addr1_q;
  assign mem_addr2 = (state == S_FETCH) ? fetch_a2 : addr2_q;
  assign win_row   = row;
  assign win_col   = col;

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < 9; i++)
      win_data[i*DATA_W +: DATA_W] = taps[i];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_en    = 1'b0;
    win_valid = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        busy   = 1'b1;
        mem_en = 1'b1;
        if (k == 3'd4) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        state_nxt = S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        win_valid = 1'b1;
        if (win_ready) state_nxt = last_win ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row     <= '0;
      col     <= '0;
      k       <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
      for (int unsigned i = 0; i < 9; i++) taps[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            row <= '0;
            col <= '0;
            k   <= '0;
          end
        end
        S_FETCH: begin
          addr1_q <= fetch_a1;
          addr2_q <= fetch_a2;
          k       <= (k == 3'd4) ? 3'd0 : k + 3'd1;
          // Data returning now belongs to the pair issued one cycle earlier.
          if (k != 3'd0) begin
            taps[cap_idx]        <= mem_data1;
            taps[cap_idx + 4'd1] <= mem_data2;
          end
        end
        S_DRAIN: taps[8] <= mem_data1;
        S_OUT: begin
          if (win_ready && !last_win) begin
            k <= '0;
            if (col == LAST_COL) begin
              col <= '0;
              row <= row + 5'd1;
            end else begin
              col <= col + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_fetch.sv
`timescale 1ns/1ps
// Directed bench for conv_window_fetch against a 28x28 memory preloaded with i mod 256.
module tb_conv_window_fetch;

  logic        clk = 1'b0;
  logic        rst, start, win_ready;
  logic        busy, done, mem_en, win_valid;
  logic [9:0]  mem_addr1, mem_addr2;
  logic [7:0]  mem_data1, mem_data2;
  logic [71:0] win_data;
  logic [4:0]  win_row, win_col;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conv_window_fetch #(.IMG_W(28), .IMG_H(28), .DATA_W(8), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
    .mem_data1(mem_data1), .mem_data2(mem_data2),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col)
  );

  // Image memory: two registered read ports gated by mem_en.
  logic [7:0] mem [784];
  initial for (int i = 0; i < 784; i++) mem[i] = 8'(i % 256);
  initial begin mem_data1 = '0; mem_data2 = '0; end
  always @(posedge clk) begin
    if (mem_en) begin
      mem_data1 <= mem[mem_addr1];
      mem_data2 <= mem[mem_addr2];
    end
  end

  // Transfer / done monitor, sampled on the falling edge.
  int          n_xfer = 0;
  int          n_done = 0;
  int          rec_row [676];
  int          rec_col [676];
  logic [71:0] rec_data [676];
  always @(negedge clk) begin
    if (!rst) begin
      if (win_valid && win_ready) begin
        if (n_xfer < 676) begin
          rec_row[n_xfer]  = int'(win_row);
          rec_col[n_xfer]  = int'(win_col);
          rec_data[n_xfer] = win_data;
        end
        n_xfer++;
      end
      if (done) n_done++;
    end
  end

  typedef struct {
    int r;
    int c;
    int t [9];
  } win_vec_t;

  typedef struct {
    int a1;
    int a2;
  } addr_vec_t;

  win_vec_t  wins  [6];
  addr_vec_t pairs [5];

  function automatic logic [71:0] pack(input int t [9]);
    logic [71:0] v = '0;
    for (int i = 0; i < 9; i++) v[i*8 +: 8] = 8'(t[i]);
    return v;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [71:0] snap_data;
  logic [4:0]  snap_row, snap_col;
  logic        ok, found;
  int          idx;

  initial begin
    wins[0] = '{0,  0,  '{0, 1, 2, 28, 29, 30, 56, 57, 58}};
    wins[1] = '{0,  1,  '{1, 2, 3, 29, 30, 31, 57, 58, 59}};
    wins[2] = '{0,  25, '{25, 26, 27, 53, 54, 55, 81, 82, 83}};
    wins[3] = '{1,  0,  '{28, 29, 30, 56, 57, 58, 84, 85, 86}};
    wins[4] = '{3,  7,  '{91, 92, 93, 119, 120, 121, 147, 148, 149}};
    wins[5] = '{25, 25, '{213, 214, 215, 241, 242, 243, 13, 14, 15}};
    pairs[0] = '{0, 1};
    pairs[1] = '{2, 28};
    pairs[2] = '{29, 30};
    pairs[3] = '{56, 57};
    pairs[4] = '{58, 58};

    rst = 1'b1; start = 1'b0; win_ready = 1'b0;
    repeat (3) step();
    chk("reset_ctrl", {busy, done, mem_en, win_valid, mem_addr1, mem_addr2, win_row, win_col}, '0);
    chk("reset_data", win_data, '0);

    rst = 1'b0;
    step();
    start = 1'b1; win_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fetch_pair%0d", i), {busy, mem_en, mem_addr1, mem_addr2},
          {1'b1, 1'b1, 10'(pairs[i].a1), 10'(pairs[i].a2)});
      step();
    end
    chk("drain_ctrl", {busy, mem_en, win_valid}, {1'b1, 1'b0, 1'b0});
    step();
    chk("win0_data", win_data, pack(wins[0].t));
    chk("win0_pos", {win_valid, win_row, win_col}, {1'b1, 5'd0, 5'd0});
    step();
    chk("after_xfer", {win_valid, mem_en, win_row, win_col}, {1'b0, 1'b1, 5'd0, 5'd1});
    win_ready = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (win_valid) found = 1'b1;
      else step();
    end
    chk("wait_win1", found, 1'b1);
    snap_data = win_data; snap_row = win_row; snap_col = win_col;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall_%0d", i), {win_valid, mem_en, win_data, win_row, win_col},
          {1'b1, 1'b0, snap_data, snap_row, snap_col});
      start = (i == 3);
      step();
    end
    start = 1'b0;
    win_ready = 1'b1;
    step();
    chk("win2_fetch", {mem_en, mem_addr1, mem_addr2, win_row, win_col},
        {1'b1, 10'd2, 10'd3, 5'd0, 5'd2});

    found = 1'b0;
    for (int i = 0; i < 6000 && !found; i++) begin
      if (done) found = 1'b1;
      else step();
    end
    chk("wait_done", found, 1'b1);
    chk("done_cycle", {done, busy, win_valid}, {1'b1, 1'b0, 1'b0});
    step();
    chk("after_done", {done, busy}, 2'b00);
    repeat (3) step();
    chk("xfer_count", 72'(n_xfer), 72'd676);
    chk("done_count", 72'(n_done), 72'd1);

    for (int i = 0; i < 6; i++) begin
      idx = wins[i].r * 26 + wins[i].c;
      chk($sformatf("win_%0d_%0d", wins[i].r, wins[i].c),
          {rec_data[idx], 5'(rec_row[idx]), 5'(rec_col[idx])},
          {pack(wins[i].t), 5'(wins[i].r), 5'(wins[i].c)});
    end
    ok = 1'b1;
    for (int n = 0; n < 676; n++)
      if (rec_row[n] != n / 26 || rec_col[n] != n % 26) ok = 1'b0;
    chk("scan_order", ok, 1'b1);

    // Abort a scan mid-fetch of window (3,7), then restart from scratch.
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (mem_en && win_row == 5'd3 && win_col == 5'd7) found = 1'b1;
      else step();
    end
    chk("wait_3_7", found, 1'b1);
    step();
    rst = 1'b1;
    step();
    chk("abort_ctrl", {busy, done, mem_en, win_valid, mem_addr1, mem_addr2, win_row, win_col}, '0);
    chk("abort_data", win_data, '0);
    rst = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (win_valid) found = 1'b1;
      else step();
    end
    chk("restart_win", {found, win_data, win_row, win_col}, {1'b1, pack(wins[0].t), 5'd0, 5'd0});
    chk("abort_no_done", 72'(n_done), 72'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
